// File: rtl/alu_issue_unit.sv
// Execute-stage sequencer: decodes one instruction slice, drives the combinational ALU, returns a registered response.
// Optional SLT/SLTI support is enabled by defining ALU_SLT_EN.
module alu_issue_unit #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7_b5,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [XLEN-1:0]   imm,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic              out_branch,
    output logic              out_taken,
    output logic              out_illegal
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [CTRL_W-1:0] CTRL_AND = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] CTRL_OR  = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] CTRL_SUB = CTRL_W'(4'b0110);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_use_imm;
    logic              dec_illegal;
    logic              dec_branch;
    logic              dec_bne;
    logic              is_branch;
    logic              is_bne;
    logic [XLEN-1:0]   capture;

`ifdef ALU_SLT_EN
    logic dec_slt;
    logic is_slt;
    logic ovf;
    logic lt;
`endif

    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_use_imm = 1'b0;
        dec_illegal = 1'b0;
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
`ifdef ALU_SLT_EN
        dec_slt     = 1'b0;
`endif
        case (opcode)
            OP_R, OP_I: begin
                dec_use_imm = (opcode == OP_I);
                case (funct3)
                    3'b000: dec_ctrl = (opcode == OP_R && funct7_b5) ? CTRL_SUB : CTRL_ADD;
                    3'b111: dec_ctrl = CTRL_AND;
                    3'b110: dec_ctrl = CTRL_OR;
`ifdef ALU_SLT_EN
                    3'b010: begin
                        dec_ctrl = CTRL_SUB;
                        dec_slt  = 1'b1;
                    end
`else
                    3'b010: dec_illegal = 1'b1;
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_LD, OP_ST: dec_use_imm = 1'b1;
            OP_BR: begin
                dec_ctrl   = CTRL_SUB;
                dec_branch = 1'b1;
                case (funct3)
                    3'b000:  dec_bne     = 1'b0;
                    3'b001:  dec_bne     = 1'b1;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Illegal encodings skip ISSUE entirely and respond one cycle earlier.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = dec_illegal ? RESP : ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef ALU_SLT_EN
    // Signed less-than from the subtraction: sign of the difference corrected by signed overflow.
    assign ovf     = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (alu_result[XLEN-1] != alu_a[XLEN-1]);
    assign lt      = alu_result[XLEN-1] ^ ovf;
    assign capture = is_slt ? {{(XLEN-1){1'b0}}, lt} : alu_result;
`else
    assign capture = alu_result;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= CTRL_ADD;
            out_result  <= '0;
            out_branch  <= 1'b0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
            is_branch   <= 1'b0;
            is_bne      <= 1'b0;
`ifdef ALU_SLT_EN
            is_slt      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (dec_illegal) begin
                            out_result  <= '0;
                            out_branch  <= 1'b0;
                            out_taken   <= 1'b0;
                            out_illegal <= 1'b1;
                        end else begin
                            alu_a       <= rs1_val;
                            alu_b       <= dec_use_imm ? imm : rs2_val;
                            alu_ctrl    <= dec_ctrl;
                            is_branch   <= dec_branch;
                            is_bne      <= dec_bne;
                            out_illegal <= 1'b0;
`ifdef ALU_SLT_EN
                            is_slt      <= dec_slt;
`endif
                        end
                    end
                end
                ISSUE: begin
                    out_result <= capture;
                    out_branch <= is_branch;
                    out_taken  <= is_branch & (is_bne ^ alu_zero);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: a transaction-level model checked every cycle plus literal spot checks.
// Define ALU_SLT_EN for both bench and RTL to exercise SLT/SLTI.
module tb_alu_issue_unit;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_b5 = 1'b0;
    logic [63:0] rs1_val = '0;
    logic [63:0] rs2_val = '0;
    logic [63:0] imm = '0;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;
    logic        out_branch;
    logic        out_taken;
    logic        out_illegal;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_branch(out_branch), .out_taken(out_taken), .out_illegal(out_illegal)
    );

    // Stand-in for the team's combinational ALU.
    always_comb begin
        case (alu_ctrl)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == 64'd0);

    typedef struct packed {
        logic        illegal;
        logic        branch;
        logic        taken;
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] result;
    } expect_t;

    function automatic expect_t model_expect(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                                             input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] im);
        expect_t e;
        logic [63:0] bb;
        e = '0;
        e.illegal = 1'b1;
        bb = (op == OP_R) ? r2 : im;
        if (op == OP_R || op == OP_I) begin
            e.a = r1;
            e.b = bb;
            if (f3 == 3'b000) begin
                e.illegal = 1'b0;
                if (op == OP_R && b5) begin e.ctrl = 4'b0110; e.result = r1 - bb; end
                else begin e.ctrl = 4'b0010; e.result = r1 + bb; end
            end else if (f3 == 3'b111) begin
                e.illegal = 1'b0; e.ctrl = 4'b0000; e.result = r1 & bb;
            end else if (f3 == 3'b110) begin
                e.illegal = 1'b0; e.ctrl = 4'b0001; e.result = r1 | bb;
            end
`ifdef ALU_SLT_EN
            else if (f3 == 3'b010) begin
                e.illegal = 1'b0; e.ctrl = 4'b0110;
                e.result = ($signed(r1) < $signed(bb)) ? 64'd1 : 64'd0;
            end
`endif
        end else if (op == OP_LD || op == OP_ST) begin
            e.illegal = 1'b0; e.ctrl = 4'b0010; e.a = r1; e.b = im; e.result = r1 + im;
        end else if (op == OP_BR && (f3 == 3'b000 || f3 == 3'b001)) begin
            e.illegal = 1'b0; e.branch = 1'b1; e.ctrl = 4'b0110; e.a = r1; e.b = r2;
            e.result = r1 - r2;
            e.taken = (f3 == 3'b000) ? (r1 == r2) : (r1 != r2);
        end
        if (e.illegal) begin
            e = '0;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    expect_t nxt;
    expect_t cur = '0;
    logic    busy = 1'b0;
    int      cyc = 0;
    int      vat = 0;

    assign nxt = model_expect(opcode, funct3, funct7_b5, rs1_val, rs2_val, imm);

    // Transaction model: one instruction in flight; response visible from cycle vat until consumed.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cyc  <= 0;
        end else begin
            cyc <= cyc + 1;
            if (busy) begin
                if (cyc >= vat && out_ready) busy <= 1'b0;
            end else if (in_valid) begin
                busy <= 1'b1;
                cur  <= nxt;
                vat  <= cyc + 1 + (nxt.illegal ? 0 : 1);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("in_ready", 64'(in_ready), 64'(!busy));
        checkOutput("out_valid", 64'(out_valid), 64'(busy && cyc >= vat));
        if (busy && cyc >= vat) begin
            checkOutput("out_result", out_result, cur.result);
            checkOutput("out_branch", 64'(out_branch), 64'(cur.branch));
            checkOutput("out_taken", 64'(out_taken), 64'(cur.taken));
            checkOutput("out_illegal", 64'(out_illegal), 64'(cur.illegal));
        end
        if (busy && !cur.illegal && cyc == vat - 1) begin
            checkOutput("issue_ctrl", 64'(alu_ctrl), 64'(cur.ctrl));
            checkOutput("issue_a", alu_a, cur.a);
            checkOutput("issue_b", alu_b, cur.b);
        end
    end

    // hold < 0 keeps out_ready high for the whole transaction; otherwise out_ready rises after hold cycles of RESP.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                                 input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] im,
                                 input int hold, output int lat, output logic [63:0] res,
                                 output logic br, output logic tk, output logic ill);
        int n;
        @(negedge clk); #1;
        opcode = op; funct3 = f3; funct7_b5 = b5;
        rs1_val = r1; rs2_val = r2; imm = im;
        out_ready = (hold < 0);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        res = out_result; br = out_branch; tk = out_taken; ill = out_illegal;
        if (hold >= 0) begin
            repeat (hold) begin
                @(negedge clk);
                checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            end
            @(negedge clk); #1;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    int          lat;
    logic [63:0] res;
    logic        br, tk, ill;

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_alu_ctrl", 64'(alu_ctrl), 64'h2);
        checkOutput("rst_out_result", out_result, 64'd0);
        checkOutput("rst_alu_a", alu_a, 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        #1 reset = 1'b0;

        applyStimulus(OP_R, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0, 0, lat, res, br, tk, ill);
        checkOutput("add_result", res, 64'd12);
        checkOutput("add_latency", 64'(lat), 64'd2);
        checkOutput("add_illegal", 64'(ill), 64'd0);

        applyStimulus(OP_R, 3'b000, 1'b1, 64'd0, 64'd1, 64'd0, 1, lat, res, br, tk, ill);
        checkOutput("sub_wrap", res, 64'hFFFF_FFFF_FFFF_FFFF);

        applyStimulus(OP_BR, 3'b000, 1'b0, 64'h10, 64'h10, 64'd0, -1, lat, res, br, tk, ill);
        checkOutput("beq_branch", 64'(br), 64'd1);
        checkOutput("beq_taken", 64'(tk), 64'd1);
        checkOutput("beq_result", res, 64'd0);

        applyStimulus(OP_BR, 3'b001, 1'b0, 64'h10, 64'h10, 64'd0, 0, lat, res, br, tk, ill);
        checkOutput("bne_taken", 64'(tk), 64'd0);
        checkOutput("bne_result", res, 64'd0);

        applyStimulus(OP_BR, 3'b000, 1'b0, 64'h10, 64'h11, 64'd0, 0, lat, res, br, tk, ill);
        checkOutput("beq_not_taken", 64'(tk), 64'd0);

        applyStimulus(OP_JAL, 3'b000, 1'b0, 64'd3, 64'd4, 64'd5, 4, lat, res, br, tk, ill);
        checkOutput("illegal_latency", 64'(lat), 64'd1);
        checkOutput("illegal_flag", 64'(ill), 64'd1);
        checkOutput("illegal_result", res, 64'd0);

        applyStimulus(OP_BR, 3'b100, 1'b0, 64'd1, 64'd1, 64'd0, -1, lat, res, br, tk, ill);
        checkOutput("blt_illegal", 64'(ill), 64'd1);

        applyStimulus(OP_I, 3'b000, 1'b1, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, lat, res, br, tk, ill);
        checkOutput("addi_b5_ignored", res, 64'd98);

        applyStimulus(OP_LD, 3'b011, 1'b0, 64'h1000, 64'd9, 64'h20, 0, lat, res, br, tk, ill);
        checkOutput("load_addr", res, 64'h1020);

        applyStimulus(OP_ST, 3'b010, 1'b1, 64'h2000, 64'd9, 64'h8, -1, lat, res, br, tk, ill);
        checkOutput("store_addr", res, 64'h2008);

        // Reset lands while ORI is in ISSUE; it must vanish without a response.
        @(negedge clk); #1;
        opcode = OP_I; funct3 = 3'b110; funct7_b5 = 1'b0;
        rs1_val = 64'hF0; rs2_val = 64'd0; imm = 64'h0F;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("post_rst_no_resp", 64'(out_valid), 64'd0);
        end

        applyStimulus(OP_I, 3'b111, 1'b0, 64'hFF, 64'd0, 64'h0F, 0, lat, res, br, tk, ill);
        checkOutput("andi_result", res, 64'h0F);

`ifdef ALU_SLT_EN
        applyStimulus(OP_R, 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, lat, res, br, tk, ill);
        checkOutput("slt_neg", res, 64'd1);
        applyStimulus(OP_R, 3'b010, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 0, lat, res, br, tk, ill);
        checkOutput("slt_min", res, 64'd1);
        applyStimulus(OP_I, 3'b010, 1'b0, 64'd5, 64'd0, 64'd3, 0, lat, res, br, tk, ill);
        checkOutput("slti_false", res, 64'd0);
`else
        applyStimulus(OP_R, 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, lat, res, br, tk, ill);
        checkOutput("slt_illegal", 64'(ill), 64'd1);
        applyStimulus(OP_I, 3'b010, 1'b0, 64'd5, 64'd0, 64'd3, 0, lat, res, br, tk, ill);
        checkOutput("slti_illegal", 64'(ill), 64'd1);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
